// File: rtl/tally_update_scheduler.sv
// Tally score controller: edge-detects debounced Inc/Dec/Clr buttons, arbitrates
// them by fixed priority and produces single-step and hold-to-repeat score updates.
module tally_update_scheduler #(
    parameter int WIDTH         = 8,
    parameter int REPEAT_DELAY  = 12500000,
    parameter int REPEAT_PERIOD = 2500000,
    parameter int SATURATE      = 0
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_Inc,
    input  logic             i_Dec,
    input  logic             i_Clr,
    output logic [WIDTH-1:0] o_Score,
    output logic             o_Update,
    output logic             o_Repeating
);

    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        REPEAT   = 2'd2,
        CLR_WAIT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [WIDTH-1:0]  score_q, score_d;
    logic              dir_up_q, dir_up_d;
    logic              inc_prev_q, dec_prev_q, clr_prev_q;
    logic              update_q, repeating_q;
    logic              inc_press, dec_press, clr_press, granted;

    // A clamped step returns the input unchanged, so no update pulse follows.
    function automatic logic [WIDTH-1:0] step_score(input logic [WIDTH-1:0] s,
                                                    input logic up);
        logic [WIDTH-1:0] r;
        if (up) begin
            r = ((SATURATE != 0) && (s == {WIDTH{1'b1}})) ? s : s + 1'b1;
        end else begin
            r = ((SATURATE != 0) && (s == {WIDTH{1'b0}})) ? s : s - 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        score_d   = score_q;
        dir_up_d  = dir_up_q;
        inc_press = i_Inc & ~inc_prev_q;
        dec_press = i_Dec & ~dec_prev_q;
        clr_press = i_Clr & ~clr_prev_q;
        granted   = dir_up_q ? i_Inc : i_Dec;

        case (state_q)
            IDLE: begin
                if (clr_press) begin
                    score_d = '0;
                    state_d = CLR_WAIT;
                end else if (inc_press || dec_press) begin
                    score_d  = step_score(score_q, inc_press);
                    dir_up_d = inc_press;
                    timer_d  = '0;
                    state_d  = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (i_Clr) begin
                    score_d = '0;
                    timer_d = '0;
                    state_d = CLR_WAIT;
                end else if (!granted) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else if (timer_q == ((state_q == HOLD) ? DELAY_LAST : PERIOD_LAST)) begin
                    score_d = step_score(score_q, dir_up_q);
                    timer_d = '0;
                    state_d = REPEAT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CLR_WAIT: begin
                if (!i_Inc && !i_Dec && !i_Clr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Edge registers reset high so a button already held at reset release is not a press.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            score_q     <= '0;
            dir_up_q    <= 1'b0;
            inc_prev_q  <= 1'b1;
            dec_prev_q  <= 1'b1;
            clr_prev_q  <= 1'b1;
            update_q    <= 1'b0;
            repeating_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            score_q     <= score_d;
            dir_up_q    <= dir_up_d;
            inc_prev_q  <= i_Inc;
            dec_prev_q  <= i_Dec;
            clr_prev_q  <= i_Clr;
            update_q    <= (score_d != score_q);
            repeating_q <= (state_q == REPEAT);
        end
    end

    assign o_Score     = score_q;
    assign o_Update    = update_q;
    assign o_Repeating = repeating_q;

endmodule
